// File: rtl/download_tx.sv
// download_tx: memory-dump UART transmitter sending a 16-bit length header then LENGTH bytes as 8N1
// Ports:
//   clk, rst_n (async active-low), clk_enable (global advance, everything holds when low)
//   start/length/base_addr : dump request, sampled only when idle
//   mem_re/mem_addr/mem_rdata : memory read port, data valid one enabled cycle after mem_re
//   tx : serial line (idle high); busy : dump in progress; done : one-cycle completion pulse
module download_tx #(
  parameter int CLOCK_RATE = 25175000,
  parameter int BAUD_RATE  = 9600,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_enable,
  input  logic                  start,
  input  logic [15:0]           length,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);
  localparam int CPB = CLOCK_RATE / BAUD_RATE;
  localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, FETCH, WAIT, SHIFT, FINISH} state_t;
  state_t r_state, w_next;
  logic [15:0]           r_len, r_rem;
  logic [1:0]            r_idx;
  logic [ADDR_WIDTH-1:0] r_cur, r_addr;
  logic [9:0]            r_frame;
  logic [3:0]            r_bit;
  logic [BW-1:0]         r_baud;
  logic                  w_bit_end, w_frame_end;
  assign w_bit_end   = r_baud == BW'(CPB - 1);
  assign w_frame_end = w_bit_end && r_bit == 4'd9;
  assign mem_re   = r_state == FETCH;
  assign mem_addr = r_addr;
  assign done     = r_state == FINISH;
  assign busy     = r_state != IDLE && r_state != FINISH;
  // The frame register holds {stop, data, start}; bit 0 is always the bit on the line.
  assign tx       = r_state == SHIFT ? r_frame[0] : 1'b1;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? LOAD : IDLE;
      LOAD:    w_next = r_idx < 2'd2 ? SHIFT : (r_rem != 16'd0 ? FETCH : FINISH);
      FETCH:   w_next = WAIT;
      WAIT:    w_next = SHIFT;
      SHIFT:   w_next = w_frame_end ? LOAD : SHIFT;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else if (clk_enable) r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len   <= '0;
      r_rem   <= '0;
      r_idx   <= '0;
      r_cur   <= '0;
      r_addr  <= '0;
      r_frame <= '1;
      r_bit   <= '0;
      r_baud  <= '0;
    end else if (clk_enable) begin
      case (r_state)
        IDLE: if (start) begin
          r_len <= length;
          r_rem <= length;
          r_cur <= base_addr;
          r_idx <= '0;
        end
        LOAD: begin
          // r_idx saturates at 2: the two header bytes come from the latched length.
          if (r_idx < 2'd2) begin
            r_frame <= {1'b1, r_idx[0] ? r_len[7:0] : r_len[15:8], 1'b0};
            r_idx   <= r_idx + 2'd1;
          end else if (r_rem != 16'd0) r_addr <= r_cur;
          r_baud <= '0;
          r_bit  <= '0;
        end
        WAIT: begin
          r_frame <= {1'b1, mem_rdata, 1'b0};
          r_cur   <= r_cur + 1'b1;
          r_rem   <= r_rem - 16'd1;
        end
        SHIFT: if (w_bit_end) begin
          r_baud  <= '0;
          r_bit   <= r_bit + 4'd1;
          r_frame <= {1'b1, r_frame[9:1]};
        end else r_baud <= r_baud + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_download_tx.sv
// tb_download_tx: directed scenarios for download_tx comparing per-enabled-cycle traces against expected framing
module tb_download_tx;
  logic        clk = 0, rst_n = 0, clk_enable = 1, start = 0;
  logic [15:0] length = 0;
  logic [31:0] base_addr = 0;
  logic        mem_re, tx, busy, done;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata = 0;
  int          tests = 0, fails = 0;
  bit          tog = 0;
  logic [7:0]  mem [256];
  logic        act_tx[$], act_re[$], act_done[$], act_busy[$];
  logic [31:0] act_addr[$];
  logic        exp_tx[$], exp_re[$], exp_done[$], exp_busy[$];
  logic [31:0] exp_addr[$];

  download_tx #(.CLOCK_RATE(40), .BAUD_RATE(10), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .start(start), .length(length),
    .base_addr(base_addr), .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .tx(tx), .busy(busy), .done(done));

  always #5 clk = ~clk;

  always @(posedge clk) if (clk_enable && mem_re) mem_rdata <= mem[mem_addr[7:0]];

  always @(negedge clk)
    if (clk_enable && (busy || done)) begin
      act_tx.push_back(tx);
      act_re.push_back(mem_re);
      act_addr.push_back(mem_addr);
      act_done.push_back(done);
      act_busy.push_back(busy);
    end

  initial forever begin
    @(posedge clk);
    #1;
    clk_enable = tog ? ~clk_enable : 1'b1;
  end

  task automatic add(input logic t, input logic re, input logic [31:0] a, input logic d, input logic b);
    exp_tx.push_back(t);
    exp_re.push_back(re);
    exp_addr.push_back(a);
    exp_done.push_back(d);
    exp_busy.push_back(b);
  endtask

  task automatic frame(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) repeat (4) add(f[k], 0, 0, 0, 1);
  endtask

  task automatic build(input logic [15:0] len, input logic [31:0] ba);
    logic [31:0] a;
    exp_tx.delete(); exp_re.delete(); exp_addr.delete(); exp_done.delete(); exp_busy.delete();
    add(1, 0, 0, 0, 1);
    frame(len[15:8]);
    add(1, 0, 0, 0, 1);
    frame(len[7:0]);
    for (int i = 0; i < int'(len); i++) begin
      a = ba + 32'(i);
      add(1, 0, 0, 0, 1);
      add(1, 1, a, 0, 1);
      add(1, 0, 0, 0, 1);
      frame(mem[a[7:0]]);
    end
    add(1, 0, 0, 0, 1);
    add(1, 0, 0, 1, 0);
  endtask

  task automatic go(input logic [15:0] len, input logic [31:0] ba, output int b0);
    @(posedge clk);
    #1;
    length = len;
    base_addr = ba;
    start = 1;
    b0 = act_tx.size();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) break;
    end
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL start_accept: busy=%b expected 1", busy); end
    start = 0;
  endtask

  task automatic wait_idle(input string nm);
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (!busy && !done) break;
    end
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || tx !== 1'b1) begin
      fails++;
      $display("FAIL %s_idle: busy=%b done=%b tx=%b expected 0 0 1", nm, busy, done, tx);
    end
  endtask

  function automatic int cnt(input int b0, input int w);
    int c = 0;
    for (int i = b0; i < act_tx.size(); i++)
      c += int'(w == 0 ? act_re[i] : w == 1 ? act_done[i] : act_busy[i]);
    return c;
  endfunction

  task automatic check_trace(input string nm, input int b0);
    int n, bt, br, bd, bb, ft, fr, fd, fb;
    n = act_tx.size() - b0;
    bt = 0; br = 0; bd = 0; bb = 0; ft = 0; fr = 0; fd = 0; fb = 0;
    tests++;
    if (n != exp_tx.size()) begin
      fails++;
      $display("FAIL %s_len: got %0d cycles expected %0d", nm, n, exp_tx.size());
    end
    for (int i = 0; i < n && i < exp_tx.size(); i++) begin
      if (act_tx[b0+i] !== exp_tx[i]) begin if (bt == 0) ft = i; bt++; end
      if (act_re[b0+i] !== exp_re[i] || (exp_re[i] && act_addr[b0+i] !== exp_addr[i])) begin
        if (br == 0) fr = i;
        br++;
      end
      if (act_done[b0+i] !== exp_done[i]) begin if (bd == 0) fd = i; bd++; end
      if (act_busy[b0+i] !== exp_busy[i]) begin if (bb == 0) fb = i; bb++; end
    end
    tests++;
    if (bt != 0) begin
      fails++;
      $display("FAIL %s_tx: %0d cycles differ, first at %0d got %b expected %b", nm, bt, ft, act_tx[b0+ft], exp_tx[ft]);
    end
    tests++;
    if (br != 0) begin
      fails++;
      $display("FAIL %s_mem: %0d cycles differ, first at %0d got re=%b addr=%h expected re=%b addr=%h",
               nm, br, fr, act_re[b0+fr], act_addr[b0+fr], exp_re[fr], exp_addr[fr]);
    end
    tests++;
    if (bd != 0) begin
      fails++;
      $display("FAIL %s_done: %0d cycles differ, first at %0d got %b expected %b", nm, bd, fd, act_done[b0+fd], exp_done[fd]);
    end
    tests++;
    if (bb != 0) begin
      fails++;
      $display("FAIL %s_busy: %0d cycles differ, first at %0d got %b expected %b", nm, bb, fb, act_busy[b0+fb], exp_busy[fb]);
    end
  endtask

  task automatic test_reset;
    #2;
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || mem_re !== 1'b0 || mem_addr !== 32'h0) begin
      fails++;
      $display("FAIL reset: tx=%b busy=%b done=%b re=%b addr=%h expected 1 0 0 0 00000000",
               tx, busy, done, mem_re, mem_addr);
    end
    repeat (3) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_basic;
    int b0, c;
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'hFF;
    build(16'd3, 32'h100);
    go(16'd3, 32'h100, b0);
    wait_idle("basic");
    check_trace("basic", b0);
    c = cnt(b0, 0);
    tests++;
    if (c != 3) begin fails++; $display("FAIL basic_reads: got %0d expected 3", c); end
    c = cnt(b0, 1);
    tests++;
    if (c != 1) begin fails++; $display("FAIL basic_done_count: got %0d expected 1", c); end
  endtask

  task automatic test_zero;
    int b0, c;
    build(16'd0, 32'h40);
    go(16'd0, 32'h40, b0);
    wait_idle("zero");
    check_trace("zero", b0);
    c = cnt(b0, 0);
    tests++;
    if (c != 0) begin fails++; $display("FAIL zero_reads: got %0d expected 0", c); end
    c = cnt(b0, 2);
    tests++;
    if (c != 83) begin fails++; $display("FAIL zero_busy_cycles: got %0d expected 83", c); end
  endtask

  task automatic test_wrap;
    int b0;
    mem[8'hFF] = 8'h5A; mem[0] = 8'hC3;
    build(16'd2, 32'hFFFF_FFFF);
    go(16'd2, 32'hFFFF_FFFF, b0);
    wait_idle("wrap");
    check_trace("wrap", b0);
  endtask

  task automatic test_restart_ignored;
    int b0, c;
    build(16'd3, 32'h100);
    go(16'd3, 32'h100, b0);
    repeat (100) @(negedge clk);
    length = 16'd5;
    base_addr = 32'h200;
    start = 1;
    repeat (3) @(negedge clk);
    start = 0;
    wait_idle("restart");
    check_trace("restart", b0);
    c = 0;
    repeat (30) begin
      @(negedge clk);
      c += int'(busy);
    end
    tests++;
    if (c != 0) begin fails++; $display("FAIL restart_second_dump: busy cycles %0d expected 0", c); end
  endtask

  task automatic test_enable_toggle;
    int b0;
    build(16'd3, 32'h100);
    tog = 1;
    go(16'd3, 32'h100, b0);
    wait_idle("toggle");
    tog = 0;
    check_trace("toggle", b0);
  endtask

  task automatic test_reset_mid;
    int b0;
    build(16'd3, 32'h100);
    go(16'd3, 32'h100, b0);
    for (int k = 0; k < 400; k++) begin
      if (act_tx.size() - b0 >= 100) break;
      @(negedge clk);
    end
    tests++;
    if (act_tx.size() - b0 < 100) begin
      fails++;
      $display("FAIL midreset_reach: got %0d cycles expected 100", act_tx.size() - b0);
    end
    #2;
    rst_n = 0;
    #1;
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || mem_re !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL midreset_state: tx=%b busy=%b re=%b done=%b expected 1 0 0 0", tx, busy, mem_re, done);
    end
    @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      fails++;
      $display("FAIL midreset_no_resume: busy=%b tx=%b expected 0 1", busy, tx);
    end
    build(16'd3, 32'h100);
    go(16'd3, 32'h100, b0);
    wait_idle("after_reset");
    check_trace("after_reset", b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 1);
    test_reset;
    test_basic;
    test_zero;
    test_wrap;
    test_restart_ignored;
    test_enable_toggle;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
